// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory handshake, timeout abort and ALU decode
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             equalrsrt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pcsrc,
  output logic             reg_we,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam int WW = $clog2(MEM_TIMEOUT);
  logic [3:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, timeout, legal;
  logic [2:0]       fn_ctl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    waiting = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready;
    timeout = waiting && wait_q == WW'(MEM_TIMEOUT - 1);
    wait_d  = (waiting && !timeout) ? wait_q + WW'(1) : '0;
    legal   = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J};
    cnt_d   = cnt_q + CNT_W'(instr_done);
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:            state_d = S_EXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : timeout ? S_FETCH : S_MEMRD;
      S_MEMWR:  state_d = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pcsrc      = 2'b00;
    reg_we     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = !legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        pc_we      = equalrsrt;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = opcode == OP_SLTI ? 2'b11 : 2'b00;
      end
      S_IWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    mem_err = timeout;
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end
  always_comb begin
    case (funct)
      6'h20:   fn_ctl = 3'b010;
      6'h22:   fn_ctl = 3'b110;
      6'h24:   fn_ctl = 3'b000;
      6'h25:   fn_ctl = 3'b001;
      6'h2A:   fn_ctl = 3'b111;
      default: fn_ctl = 3'b000;
    endcase
    alucontrol = aluop == 2'b10 ? fn_ctl : aluop == 2'b01 ? 3'b110 : aluop == 2'b11 ? 3'b111 : 3'b010;
  end
  assign state       = state_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed instruction stream checked cycle-by-cycle against a per-instruction step model
module tb_mips_multicycle_ctrl;
  localparam int T  = 4;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic equalrsrt = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, iord, ir_we, pc_we, reg_we, regdst, memtoreg, alusrca;
  logic instr_done, illegal, mem_err;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [CW-1:0] instr_count;
  logic [28:0] act_v, exp_v;
  logic [CW-1:0] exp_cnt = '0;
  bit chk_en = 1'b0;
  int checks = 0, passed = 0, ncyc = 0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .equalrsrt(equalrsrt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pcsrc(pcsrc), .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .alucontrol(alucontrol), .state(state),
    .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err), .instr_count(instr_count)
  );
  assign act_v = {mem_req, mem_we, iord, ir_we, pc_we, pcsrc, reg_we, regdst, memtoreg, alusrca,
                  alusrcb, aluop, state, instr_done, illegal, mem_err, alucontrol, instr_count};
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [2:0] alu_ctl(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b00) return 3'b010;
    if (aop == 2'b01) return 3'b110;
    if (aop == 2'b11) return 3'b111;
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic [28:0] model(input int st, input logic [5:0] op, input logic [5:0] fn,
      input logic eq, input logic rdy, input logic tmo, input logic done, input logic ill,
      input logic [CW-1:0] cnt);
    logic mreq = 0, mwe = 0, ad = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0;
    case (st)
      0: begin mreq = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mreq = 1; ad = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mreq = 1; mwe = 1; ad = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = eq; end
      9: begin sa = 1; sb = 2'b10; ao = (op == 6'h0A) ? 2'b11 : 2'b00; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {mreq, mwe, ad, irw, pcw, ps, rw, rd, m2r, sa, sb, ao, 4'(st), done, ill, tmo,
            alu_ctl(ao, fn), cnt};
  endfunction
  always @(negedge clk) if (chk_en) check("outputs", 64'(act_v), 64'(exp_v));
  task automatic cyc(input int st, input bit rdy, input bit tmo, input bit done, input bit ill);
    mem_ready = rdy;
    exp_v = model(st, opcode, funct, equalrsrt, rdy, tmo, done, ill, exp_cnt);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    ncyc++;
    if (done) exp_cnt++;
  endtask
  // lo_f / lo_m: mem_ready-low cycles before ready in fetch / in the data access
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic eq,
      input int lo_f, input int lo_m);
    int seq[$];
    bit r, tmo, legal;
    legal = 1'b1;
    case (op)
      6'h00: seq = {6, 7};
      6'h23: seq = {2, 3, 4};
      6'h2B: seq = {2, 5};
      6'h04: seq = {8};
      6'h08, 6'h0A: seq = {9, 10};
      6'h02: seq = {11};
      default: legal = 1'b0;
    endcase
    opcode = op;
    funct = fn;
    ncyc = 0;
    for (int k = 0; k < 100; k++) begin
      r = k >= lo_f;
      equalrsrt = 1'($urandom);
      cyc(0, r, !r && (k + 1) % T == 0, 1'b0, 1'b0);
      if (r) break;
    end
    equalrsrt = 1'($urandom);
    cyc(1, 1'($urandom), 1'b0, 1'b0, !legal);
    if (!legal) return;
    foreach (seq[i]) begin
      equalrsrt = (seq[i] == 8) ? eq : 1'($urandom);
      if (seq[i] == 3 || seq[i] == 5) begin
        for (int k = 0; k < 100; k++) begin
          r = k >= lo_m;
          tmo = !r && k == T - 1;
          cyc(seq[i], r, tmo, r && seq[i] == 5, 1'b0);
          if (tmo) return;
          if (r) break;
        end
      end else cyc(seq[i], 1'($urandom), 1'b0, i == seq.size() - 1, 1'b0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    check("reset_state", 64'(state), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_count", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6'h00, 6'h20, 1'b0, 0, 0);
    check("add_cycles", 64'(ncyc), 64'd4);
    check("add_count", 64'(instr_count), 64'd1);
    run(6'h23, 6'h00, 1'b0, 0, 3);
    check("lw_wait_cycles", 64'(ncyc), 64'd8);
    run(6'h04, 6'h00, 1'b1, 0, 0);
    check("beq_cycles", 64'(ncyc), 64'd3);
    run(6'h04, 6'h00, 1'b0, 0, 0);
    run(6'h3F, 6'h00, 1'b0, 0, 0);
    check("illegal_cycles", 64'(ncyc), 64'd2);
    check("illegal_count", 64'(instr_count), 64'd4);
    run(6'h2B, 6'h00, 1'b0, 0, 4);
    check("sw_timeout_cycles", 64'(ncyc), 64'd7);
    check("sw_timeout_count", 64'(instr_count), 64'd4);
    run(6'h2B, 6'h00, 1'b0, 0, 3);
    check("sw_late_ready_count", 64'(instr_count), 64'd5);
    run(6'h08, 6'h00, 1'b0, 0, 0);
    run(6'h0A, 6'h00, 1'b0, 0, 0);
    run(6'h02, 6'h00, 1'b0, 0, 0);
    check("j_cycles", 64'(ncyc), 64'd3);
    run(6'h00, 6'h22, 1'b0, 5, 0);
    check("fetch_retry_cycles", 64'(ncyc), 64'd9);
    run(6'h00, 6'h24, 1'b0, 0, 0);
    run(6'h00, 6'h25, 1'b0, 0, 0);
    run(6'h00, 6'h2A, 1'b0, 0, 0);
    run(6'h23, 6'h00, 1'b0, 0, 0);
    check("lw_cycles", 64'(ncyc), 64'd5);
    run(6'h2B, 6'h00, 1'b0, 0, 0);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    check("count_wrap", 64'(instr_count), 64'd0);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    check("count_after_wrap", 64'(instr_count), 64'd1);
    opcode = 6'h23;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrd_reset_state", 64'(state), 64'd0);
    check("midrd_reset_mem_req", 64'(mem_req), 64'd0);
    check("midrd_reset_reg_we", 64'(reg_we), 64'd0);
    check("midrd_reset_count", 64'(instr_count), 64'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6'h00, 6'h20, 1'b0, 0, 0);
    check("post_reset_count", 64'(instr_count), 64'd1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
